// File: rtl/pll_cfg_pkg.sv
// Shared definitions for the PLL reprogramming sequencer: FSM states, the
// PLL register map and the divider word layout.
package pll_cfg_pkg;

    typedef enum logic [3:0] {
        ST_IDLE,
        ST_BYPASS,
        ST_DISABLE,
        ST_WR_DIV,
        ST_ENABLE,
        ST_POLL_RD,
        ST_POLL_GAP,
        ST_SWITCH,
        ST_ERR_OFF
    } pll_state_e;

    localparam logic [7:0] OFF_CTRL    = 8'h0;
    localparam logic [7:0] OFF_DIV     = 8'h4;
    localparam logic [7:0] OFF_STATUS  = 8'h8;
    localparam logic [7:0] OFF_CLK_SEL = 8'hC;

    localparam int LOCK_BIT    = 0;
    localparam int EN_BIT      = 0;
    localparam int CLK_SEL_BIT = 0;

    localparam int DIV_M_LSB  = 0;
    localparam int DIV_M_W    = 8;
    localparam int DIV_N_LSB  = 8;
    localparam int DIV_N_W    = 8;
    localparam int DIV_OD_LSB = 16;
    localparam int DIV_OD_W   = 2;

    function automatic logic [31:0] pll_div_pack(input logic [DIV_OD_W-1:0] od,
                                                 input logic [DIV_N_W-1:0]  n,
                                                 input logic [DIV_M_W-1:0]  m);
        logic [31:0] w;
        w = '0;
        w[DIV_M_LSB  +: DIV_M_W]  = m;
        w[DIV_N_LSB  +: DIV_N_W]  = n;
        w[DIV_OD_LSB +: DIV_OD_W] = od;
        return w;
    endfunction

endpackage

// File: rtl/pll_reg_xfer.sv
// Single-outstanding-transaction master for the PLL valid/ready/rd_valid port.
// Holds the request until accepted and signals completion to the sequencer.
module pll_reg_xfer #(
    parameter int AW = 32,
    parameter int DW = 32
) (
    input  logic          clk_i,
    input  logic          rst_ni,
    input  logic          issue_i,
    input  logic          wr_i,
    input  logic [AW-1:0] addr_i,
    input  logic [DW-1:0] wdata_i,
    output logic          valid_o,
    output logic          rd0_wr1_o,
    output logic [AW-1:0] addr_o,
    output logic [DW-1:0] wr_data_o,
    input  logic          ready_i,
    input  logic          rd_valid_i,
    input  logic [DW-1:0] rd_data_i,
    output logic          done_o,
    output logic [DW-1:0] rd_data_o
);

    logic          valid_q, wr_q, rd_pend_q, rd_done_q;
    logic [AW-1:0] addr_q;
    logic [DW-1:0] wdata_q, rdata_q;
    logic          hs;

    assign hs = valid_q & ready_i;

    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            valid_q   <= 1'b0;
            wr_q      <= 1'b0;
            addr_q    <= '0;
            wdata_q   <= '0;
            rd_pend_q <= 1'b0;
            rd_done_q <= 1'b0;
            rdata_q   <= '0;
        end else begin
            // rd_valid only counts once the read has been accepted
            rd_done_q <= rd_pend_q & rd_valid_i;
            if (rd_pend_q && rd_valid_i) begin
                rd_pend_q <= 1'b0;
                rdata_q   <= rd_data_i;
            end
            if (hs && !wr_q) rd_pend_q <= 1'b1;
            // a new issue may land on the handshake cycle of the previous write
            if (issue_i) begin
                valid_q <= 1'b1;
                wr_q    <= wr_i;
                addr_q  <= addr_i;
                wdata_q <= wdata_i;
            end else if (hs) begin
                valid_q <= 1'b0;
            end
        end
    end

    assign valid_o   = valid_q;
    assign rd0_wr1_o = wr_q;
    assign addr_o    = addr_q;
    assign wr_data_o = wdata_q;
    assign done_o    = (hs & wr_q) | rd_done_q;
    assign rd_data_o = rdata_q;

endmodule

// File: rtl/pll_cfg_sequencer.sv
// PLL reprogramming sequencer: bypass, disable, load dividers, enable, poll
// for lock, then switch the SoC back to the PLL clock (or give up on timeout).
module pll_cfg_sequencer
    import pll_cfg_pkg::*;
#(
    parameter int                    ADDR_WIDTH = 32,
    parameter int                    DATA_WIDTH = 32,
    parameter logic [ADDR_WIDTH-1:0] BASE_ADDR  = '0,
    parameter int                    MAX_POLLS  = 1024,
    parameter int                    POLL_GAP   = 16
) (
    input  logic                             i_clk_ahb,
    input  logic                             i_rstn_ahb,
    input  logic                             i_start,
    input  logic [DATA_WIDTH-1:0]            i_div_cfg,
    output logic                             o_valid,
    output logic                             o_rd0_wr1,
    output logic [ADDR_WIDTH-1:0]            o_addr,
    output logic [DATA_WIDTH-1:0]            o_wr_data,
    input  logic                             i_ready,
    input  logic                             i_rd_valid,
    input  logic [DATA_WIDTH-1:0]            i_rd_data,
    output logic                             o_busy,
    output logic                             o_done,
    output logic                             o_error,
    output logic [$clog2(MAX_POLLS+1)-1:0]   o_poll_cnt
);

    localparam int PCW = $clog2(MAX_POLLS + 1);
    localparam int GCW = $clog2(POLL_GAP + 1);

    pll_state_e            state_q, state_d;
    logic [DATA_WIDTH-1:0] cfg_q;
    logic                  busy_q, done_q, error_q;
    logic [PCW-1:0]        poll_cnt_q;
    logic [GCW-1:0]        gap_cnt_q;

    logic                  x_done;
    logic [DATA_WIDTH-1:0] x_rdata;
    logic                  issue, req_wr;
    logic [7:0]            req_off;
    logic [DATA_WIDTH-1:0] req_data;
    logic                  rd_hs;
    logic                  unused_rdata;

    assign rd_hs        = o_valid & i_ready & ~o_rd0_wr1;
    assign unused_rdata = ^x_rdata;

    always_comb begin
        state_d  = state_q;
        issue    = 1'b0;
        req_wr   = 1'b1;
        req_off  = OFF_CTRL;
        req_data = '0;
        case (state_q)
            ST_IDLE:     if (i_start) state_d = ST_BYPASS;
            ST_BYPASS:   if (x_done) state_d = ST_DISABLE;
            ST_DISABLE:  if (x_done) state_d = ST_WR_DIV;
            ST_WR_DIV:   if (x_done) state_d = ST_ENABLE;
            ST_ENABLE:   if (x_done) state_d = ST_POLL_RD;
            ST_POLL_RD: begin
                // lock wins even on the last allowed read
                if (x_done) begin
                    if (x_rdata[LOCK_BIT])                    state_d = ST_SWITCH;
                    else if (poll_cnt_q == PCW'(MAX_POLLS))   state_d = ST_ERR_OFF;
                    else                                      state_d = ST_POLL_GAP;
                end
            end
            ST_POLL_GAP: if (gap_cnt_q == GCW'(POLL_GAP - 1)) state_d = ST_POLL_RD;
            ST_SWITCH:   if (x_done) state_d = ST_IDLE;
            ST_ERR_OFF:  if (x_done) state_d = ST_IDLE;
            default:     state_d = ST_IDLE;
        endcase

        // the request for the next state is launched on the transition edge
        issue = (state_d != state_q) && !(state_d inside {ST_IDLE, ST_POLL_GAP});
        case (state_d)
            ST_BYPASS: begin
                req_off               = OFF_CLK_SEL;
                req_data[CLK_SEL_BIT] = 1'b1;
            end
            ST_WR_DIV: begin
                req_off  = OFF_DIV;
                req_data = cfg_q;
            end
            ST_ENABLE:  req_data[EN_BIT] = 1'b1;
            ST_POLL_RD: begin
                req_wr  = 1'b0;
                req_off = OFF_STATUS;
            end
            ST_SWITCH:  req_off = OFF_CLK_SEL;
            default: ;
        endcase
    end

    always_ff @(posedge i_clk_ahb or negedge i_rstn_ahb) begin
        if (!i_rstn_ahb) begin
            state_q    <= ST_IDLE;
            cfg_q      <= '0;
            busy_q     <= 1'b0;
            done_q     <= 1'b0;
            error_q    <= 1'b0;
            poll_cnt_q <= '0;
            gap_cnt_q  <= '0;
        end else begin
            state_q <= state_d;
            done_q  <= 1'b0;
            if (state_q == ST_IDLE && i_start) begin
                cfg_q      <= i_div_cfg;
                busy_q     <= 1'b1;
                error_q    <= 1'b0;
                poll_cnt_q <= '0;
            end
            if (rd_hs && poll_cnt_q != PCW'(MAX_POLLS)) poll_cnt_q <= poll_cnt_q + 1'b1;
            if (state_q == ST_POLL_GAP) gap_cnt_q <= gap_cnt_q + 1'b1;
            else                        gap_cnt_q <= '0;
            if (x_done && state_q == ST_SWITCH) begin
                done_q <= 1'b1;
                busy_q <= 1'b0;
            end
            if (x_done && state_q == ST_ERR_OFF) begin
                error_q <= 1'b1;
                busy_q  <= 1'b0;
            end
        end
    end

    pll_reg_xfer #(
        .AW (ADDR_WIDTH),
        .DW (DATA_WIDTH)
    ) u_xfer (
        .clk_i      (i_clk_ahb),
        .rst_ni     (i_rstn_ahb),
        .issue_i    (issue),
        .wr_i       (req_wr),
        .addr_i     (BASE_ADDR + ADDR_WIDTH'(req_off)),
        .wdata_i    (req_data),
        .valid_o    (o_valid),
        .rd0_wr1_o  (o_rd0_wr1),
        .addr_o     (o_addr),
        .wr_data_o  (o_wr_data),
        .ready_i    (i_ready),
        .rd_valid_i (i_rd_valid),
        .rd_data_i  (i_rd_data),
        .done_o     (x_done),
        .rd_data_o  (x_rdata)
    );

    assign o_busy     = busy_q;
    assign o_done     = done_q;
    assign o_error    = error_q;
    assign o_poll_cnt = poll_cnt_q;

endmodule

// File: tb/tb_pll_cfg_sequencer.sv
// Randomized scoreboard bench for pll_cfg_sequencer with a behavioural PLL
// register slave that locks on a chosen status read.
module tb_pll_cfg_sequencer;
    import pll_cfg_pkg::*;

    localparam int          MAXP = 4;
    localparam int          GAP  = 16;
    localparam logic [31:0] BASE = 32'h4000_0000;

    logic        clk = 1'b0;
    logic        rstn, start, ready, rd_valid;
    logic [31:0] div_cfg, rd_data;
    logic        valid, rdwr, busy, done, err;
    logic [31:0] addr, wdata;
    logic [2:0]  pcnt;

    always #5 clk = ~clk;

    pll_cfg_sequencer #(
        .ADDR_WIDTH (32),
        .DATA_WIDTH (32),
        .BASE_ADDR  (BASE),
        .MAX_POLLS  (MAXP),
        .POLL_GAP   (GAP)
    ) dut (
        .i_clk_ahb  (clk),
        .i_rstn_ahb (rstn),
        .i_start    (start),
        .i_div_cfg  (div_cfg),
        .o_valid    (valid),
        .o_rd0_wr1  (rdwr),
        .o_addr     (addr),
        .o_wr_data  (wdata),
        .i_ready    (ready),
        .i_rd_valid (rd_valid),
        .i_rd_data  (rd_data),
        .o_busy     (busy),
        .o_done     (done),
        .o_error    (err),
        .o_poll_cnt (pcnt)
    );

    typedef struct { bit wr; logic [31:0] addr; logic [31:0] data; } txn_t;
    typedef struct { bit done; bit err; int polls; } end_t;

    txn_t exp_q[$];
    end_t end_q[$];
    int   checks = 0, errors = 0;
    int   lock_at = 0, rd_cnt = 0, rd_wait = 0, div_stall = 0, seq_ends = 0;
    bit   rd_pend = 0, rd_lock = 0, hs_rd = 0;
    int   cyc = 0, last_rd = 0;
    bit   have_rd = 0, prev_busy = 0, hold = 0;
    txn_t held, t;
    end_t e;

    task automatic chk(input bit ok, input string name, input logic [95:0] act, input logic [95:0] expv);
        checks++;
        if (!ok) begin
            errors++;
            $display("FAIL %s: got %0h expected %0h", name, act, expv);
        end
    endtask

    // Reference: the register-level script implied by a given lock read index.
    task automatic push_seq(input logic [31:0] cfg, input int lk);
        bit locked;
        int n;
        locked = (lk >= 1 && lk <= MAXP);
        n      = locked ? lk : MAXP;
        exp_q.push_back('{1'b1, BASE + 32'hC, 32'h1});
        exp_q.push_back('{1'b1, BASE + 32'h0, 32'h0});
        exp_q.push_back('{1'b1, BASE + 32'h4, cfg});
        exp_q.push_back('{1'b1, BASE + 32'h0, 32'h1});
        for (int i = 0; i < n; i++) exp_q.push_back('{1'b0, BASE + 32'h8, 32'h0});
        if (locked) exp_q.push_back('{1'b1, BASE + 32'hC, 32'h0});
        else        exp_q.push_back('{1'b1, BASE + 32'h0, 32'h0});
        end_q.push_back('{locked, !locked, n});
    endtask

    // PLL register slave: random ready, delayed read data, stray rd_valid pulses.
    always begin
        @(negedge clk);
        hs_rd = rstn && valid && ready && !rdwr;
        @(posedge clk);
        #1;
        cyc++;
        if (hs_rd) begin
            rd_cnt++;
            rd_pend = 1'b1;
            rd_wait = int'($urandom_range(0, 3));
            rd_lock = (rd_cnt == lock_at);
        end
        rd_valid = 1'b0;
        rd_data  = $urandom;
        if (rd_pend) begin
            if (rd_wait == 0) begin
                rd_valid   = 1'b1;
                rd_data[0] = rd_lock;
                rd_pend    = 1'b0;
            end else begin
                rd_wait--;
            end
        end else if ($urandom_range(0, 5) == 0) begin
            rd_valid = 1'b1;
        end
        if (div_stall > 0 && valid && addr == BASE + 32'h4) begin
            ready = 1'b0;
            div_stall--;
        end else begin
            ready = ($urandom_range(0, 3) != 0);
        end
    end

    // Monitor: compares every handshake and every sequence ending against the queues.
    always begin
        @(negedge clk);
        if (!rstn) begin
            prev_busy = 1'b0;
            hold      = 1'b0;
            have_rd   = 1'b0;
        end else begin
            if (hold)
                chk(valid && addr == held.addr && wdata == held.data && rdwr == held.wr,
                    "req_stable", {valid, addr, wdata}, {1'b1, held.addr, held.data});
            hold      = valid && !ready;
            held.wr   = rdwr;
            held.addr = addr;
            held.data = wdata;
            if (valid && ready) begin
                chk(exp_q.size() != 0, "unexpected_req", addr, 0);
                if (exp_q.size() != 0) begin
                    t = exp_q.pop_front();
                    chk(rdwr == t.wr && addr == t.addr, "req_addr", {rdwr, addr}, {t.wr, t.addr});
                    if (t.wr) chk(wdata == t.data, "req_data", wdata, t.data);
                end
                if (!rdwr) begin
                    if (have_rd) chk(cyc - last_rd >= GAP, "poll_spacing", cyc - last_rd, GAP);
                    have_rd = 1'b1;
                    last_rd = cyc;
                end
            end
            if (prev_busy && !busy) begin
                chk(end_q.size() != 0, "unexpected_end", 0, 1);
                if (end_q.size() != 0) begin
                    e = end_q.pop_front();
                    chk(done == e.done, "done_pulse", done, e.done);
                    chk(err == e.err, "error_flag", err, e.err);
                    chk(pcnt == 3'(e.polls), "poll_cnt", pcnt, e.polls);
                end
                chk(exp_q.size() == 0, "missing_reqs", exp_q.size(), 0);
                exp_q.delete();
                have_rd = 1'b0;
                seq_ends++;
            end else begin
                chk(!done, "done_idle", done, 0);
            end
            prev_busy = busy;
        end
    end

    task automatic do_reset;
        @(negedge clk);
        #2;
        rstn = 1'b0;
        #1;
        chk({valid, rdwr, addr, wdata, busy, done, err, pcnt} == '0, "reset_outs",
            {valid, rdwr, addr, wdata, busy, done, err, pcnt}, 0);
        start   = 1'b0;
        rd_pend = 1'b0;
        lock_at = 0;
        exp_q.delete();
        end_q.delete();
        repeat (3) @(posedge clk);
        #1;
        rstn = 1'b1;
    endtask

    task automatic run_seq(input logic [31:0] cfg, input int lk, input bit poke);
        int ends0, n;
        push_seq(cfg, lk);
        lock_at = lk;
        rd_cnt  = 0;
        ends0   = seq_ends;
        @(posedge clk);
        #1;
        start   = 1'b1;
        div_cfg = cfg;
        @(posedge clk);
        #1;
        start   = 1'b0;
        div_cfg = $urandom;
        @(negedge clk);
        chk(busy && !err && valid, "start_accept", {busy, err, valid}, 3'b101);
        if (poke) begin
            repeat (10) @(posedge clk);
            #1;
            if (busy) begin
                start   = 1'b1;
                div_cfg = ~cfg;
                @(posedge clk);
                #1;
                start   = 1'b0;
            end
        end
        n = 0;
        while (seq_ends == ends0 && n < 3000) begin
            @(posedge clk);
            n++;
        end
        chk(seq_ends != ends0, "seq_timeout", n, 3000);
        if (seq_ends == ends0) do_reset();
    endtask

    initial begin
        logic [31:0] r;
        int          n;
        rstn = 1'b0; start = 1'b0; div_cfg = '0; ready = 1'b0; rd_valid = 1'b0; rd_data = '0;
        #2;
        chk({valid, rdwr, addr, wdata, busy, done, err, pcnt} == '0, "reset_state",
            {valid, rdwr, addr, wdata, busy, done, err, pcnt}, 0);
        repeat (3) @(posedge clk);
        #1;
        rstn = 1'b1;
        @(negedge clk);
        chk(!busy && !valid && !err && pcnt == 0, "idle_after_reset", {busy, valid, err, pcnt}, 0);

        run_seq(pll_div_pack(2'd1, 8'd20, 8'd3), 1, 1'b0);
        run_seq(pll_div_pack(2'd2, 8'd40, 8'd5), 3, 1'b0);
        run_seq(pll_div_pack(2'd3, 8'd99, 8'd7), 0, 1'b0);
        @(negedge clk);
        chk(err && !busy, "error_sticky", {err, busy}, 2'b10);
        run_seq(pll_div_pack(2'd0, 8'd12, 8'd2), 2, 1'b1);
        div_stall = 50;
        run_seq(pll_div_pack(2'd1, 8'd77, 8'd9), 1, 1'b0);
        chk(div_stall == 0, "div_stall_applied", div_stall, 0);
        div_stall = 0;
        run_seq(pll_div_pack(2'd2, 8'd55, 8'd4), MAXP, 1'b0);

        // reset in the middle of the inter-poll wait
        push_seq(32'h0001_2233, 0);
        lock_at = 0;
        rd_cnt  = 0;
        @(posedge clk); #1; start = 1'b1; div_cfg = 32'h0001_2233;
        @(posedge clk); #1; start = 1'b0;
        n = 0;
        while (!(rd_cnt >= 1 && !rd_pend) && n < 500) begin
            @(negedge clk);
            n++;
        end
        repeat (4) @(negedge clk);
        chk(busy && !valid, "in_poll_gap", {busy, valid}, 2'b10);
        do_reset();
        run_seq(pll_div_pack(2'd1, 8'd33, 8'd6), 2, 1'b0);

        for (int i = 0; i < 8; i++) begin
            r = $urandom;
            run_seq(pll_div_pack(r[17:16], r[15:8], r[7:0]), int'($urandom_range(0, MAXP)), r[31]);
        end

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
